// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32 run-control block: FSM states and next-PC selects.
package cpu_ctrl_pkg;
  typedef logic [31:0] addr_t;

  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JALR = 2'b10;

  // Any select with the top bit set is a jalr, regardless of bit 0.
  function automatic logic is_jalr(input logic [1:0] sel);
    return sel[1];
  endfunction
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Next-PC request/response bundle between the run controller and the next-PC generator.
interface cpu_run_ctrl_if;
  import cpu_ctrl_pkg::*;
  addr_t      pc;
  addr_t      imm;
  addr_t      alu_result;
  logic [1:0] sel;
  addr_t      npc;

  modport master (output pc, imm, alu_result, sel, input npc);
  modport slave  (input pc, imm, alu_result, sel, output npc);
endinterface

// File: rtl/cpu_run_ctrl_npc_gen.sv
// Purely combinational next-PC mux: sequential, PC-relative branch/jal, or jalr target.
module npc_gen
  import cpu_ctrl_pkg::*;
(
  cpu_run_ctrl_if.slave bus
);
  addr_t w_seq, w_br, w_jalr;

  // Branch offsets arrive in halfword units; all sums wrap silently.
  assign w_seq  = bus.pc + 32'd4;
  assign w_br   = bus.pc + {bus.imm[30:0], 1'b0};
  assign w_jalr = bus.alu_result & ~32'h1;

  always_comb begin
    bus.npc = w_seq;
    if (is_jalr(bus.sel))       bus.npc = w_jalr;
    else if (bus.sel == NPC_BR) bus.npc = w_br;
  end
endmodule

// File: rtl/cpu_run_ctrl.sv
// PC owner and run/step/breakpoint/halt sequencer; cpu_en gates every architectural commit.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        step_i,
  input  logic        brk_en,
  input  logic [31:0] brk_addr,
  input  logic        stop,
  input  logic [1:0]  jalmux_sel,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic        cpu_en,
  output logic [1:0]  state_o,
  output logic        halted,
  output logic [31:0] instr_cnt
);
  logic [1:0]  r_state, w_state_nxt;
  logic        r_step_q, r_resume;
  logic [31:0] r_pc, r_instr_cnt, w_npc;
  logic        w_step_pulse, w_bp_hit, w_commit;

  cpu_run_ctrl_if u_npc_bus ();

  assign u_npc_bus.pc         = r_pc;
  assign u_npc_bus.imm        = imm;
  assign u_npc_bus.alu_result = alu_result;
  assign u_npc_bus.sel        = jalmux_sel;
  assign w_npc                = u_npc_bus.npc;

  npc_gen u_npc_gen (.bus(u_npc_bus));

  assign w_step_pulse = step_i & ~r_step_q;
  // resume masks the breakpoint we just paused on so execution can move past it.
  assign w_bp_hit     = brk_en && (r_pc == brk_addr) && !r_resume;
  assign w_commit     = rst && (r_state == ST_RUN || r_state == ST_STEP) && !stop && !w_bp_hit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PAUSE: begin
        if (w_step_pulse) w_state_nxt = ST_STEP;
        else if (run_i)   w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop)          w_state_nxt = ST_HALT;
        else if (w_bp_hit) w_state_nxt = ST_PAUSE;
        else if (!run_i)   w_state_nxt = ST_PAUSE;
      end
      ST_STEP: w_state_nxt = stop ? ST_HALT : ST_PAUSE;
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_PAUSE;
      r_pc        <= PC_RESET;
      r_instr_cnt <= 32'd0;
      r_step_q    <= 1'b0;
      r_resume    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step_q <= step_i;
      if (w_commit) begin
        r_pc        <= w_npc;
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
      if (r_state == ST_PAUSE && w_state_nxt != ST_PAUSE) r_resume <= 1'b1;
      else if (w_commit)                                  r_resume <= 1'b0;
    end
  end

  assign pc        = r_pc;
  assign cpu_en    = w_commit;
  assign state_o   = r_state;
  assign halted    = (r_state == ST_HALT);
  assign instr_cnt = r_instr_cnt;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scenario bench for cpu_run_ctrl: committed PCs are scoreboarded, state/counters checked inline.
module tb_cpu_run_ctrl;
  logic        clk, rst, run_i, step_i, brk_en, stop;
  logic [31:0] brk_addr, imm, alu_result;
  logic [1:0]  jalmux_sel;
  logic [31:0] pc, instr_cnt;
  logic        cpu_en, halted;
  logic [1:0]  state_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  cpu_run_ctrl #(.PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .step_i(step_i), .brk_en(brk_en),
    .brk_addr(brk_addr), .stop(stop), .jalmux_sel(jalmux_sel), .imm(imm),
    .alu_result(alu_result), .pc(pc), .cpu_en(cpu_en), .state_o(state_o),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every commit seen must match the next PC the scenario said it would commit.
  always @(negedge clk) begin
    if (rst && cpu_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got commit at pc=%h, expected none", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc !== e) begin
          n_fail++;
          $display("FAIL commit_pc: got %h, expected %h", pc, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h0 || cpu_en !== 1'b0 || state_o !== 2'd0 || instr_cnt !== 32'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h en=%b st=%0d cnt=%h halt=%b, expected 0/0/0/0/0",
               pc, cpu_en, state_o, instr_cnt, halted);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single_step;
    exp_q.push_back(32'h0);
    step_i = 1'b1;
    tick();
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd2 || cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL step_enter: st=%0d en=%b, expected 2/1", state_o, cpu_en);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h4 || state_o !== 2'd0 || instr_cnt !== 32'd1 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL step_done: pc=%h st=%0d cnt=%0d en=%b, expected 4/0/1/0", pc, state_o, instr_cnt, cpu_en);
    end
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h4 || instr_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL step_held: pc=%h cnt=%0d, expected 4/1", pc, instr_cnt);
    end
    step_i = 1'b0;
    tick();
  endtask

  task automatic test_npc_paths;
    // From pc=4: seq 4,8,C, then branch at 0x10 back to 0x08, then jalr from 0x08.
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h8);
    run_i = 1'b1;
    repeat (4) tick();
    jalmux_sel = 2'b01;
    imm        = 32'hFFFF_FFFC;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h10 || state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL run_seq: pc=%h st=%0d, expected 10/1", pc, state_o);
    end
    tick();
    jalmux_sel = 2'b10;
    alu_result = 32'h21;
    run_i      = 1'b0;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h8) begin
      n_fail++;
      $display("FAIL npc_branch: pc=%h, expected 8", pc);
    end
    tick();
    jalmux_sel = 2'b00;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h20 || state_o !== 2'd0 || instr_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL npc_jalr: pc=%h st=%0d cnt=%0d, expected 20/0/6", pc, state_o, instr_cnt);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL npc_drain: %0d commits missing, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_breakpoint;
    do_reset();
    brk_en   = 1'b1;
    brk_addr = 32'hC;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    run_i = 1'b1;
    repeat (4) tick();
    run_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'hC || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: pc=%h en=%b, expected c/0", pc, cpu_en);
    end
    tick();
    tick();
    @(negedge clk);
    n_chk++;
    if (pc !== 32'hC || state_o !== 2'd0 || instr_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL bp_pause: pc=%h st=%0d cnt=%0d, expected c/0/3", pc, state_o, instr_cnt);
    end
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    run_i = 1'b1;
    tick();
    tick();
    run_i = 1'b0;
    tick();
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h14 || instr_cnt !== 32'd5 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_resume: pc=%h cnt=%0d st=%0d, expected 14/5/0", pc, instr_cnt, state_o);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d commits missing, expected 0", exp_q.size());
    end
    exp_q.delete();
    brk_en = 1'b0;
  endtask

  task automatic test_halt;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    run_i = 1'b1;
    repeat (3) tick();
    stop = 1'b1;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h8 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_nocommit: pc=%h en=%b, expected 8/0", pc, cpu_en);
    end
    tick();
    stop = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd3 || halted !== 1'b1 || pc !== 32'h8) begin
      n_fail++;
      $display("FAIL halt_enter: st=%0d halted=%b pc=%h, expected 3/1/8", state_o, halted, pc);
    end
    for (int i = 0; i < 4; i++) begin
      step_i = ~step_i;
      tick();
    end
    step_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd3 || pc !== 32'h8 || instr_cnt !== 32'd2 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_sticky: st=%0d pc=%h cnt=%0d en=%b, expected 3/8/2/0", state_o, pc, instr_cnt, cpu_en);
    end
    run_i = 1'b0;
    do_reset();
    @(negedge clk);
    n_chk++;
    if (halted !== 1'b0 || state_o !== 2'd0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_exit: halted=%b st=%0d pc=%h, expected 0/0/0", halted, state_o, pc);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    run_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_gate: en=%b, expected 0", cpu_en);
    end
    tick();
    rst   = 1'b1;
    run_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h0 || state_o !== 2'd0 || instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_run: pc=%h st=%0d cnt=%0d, expected 0/0/0", pc, state_o, instr_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    // Step and run together from PAUSE: step takes priority, one commit only.
    exp_q.push_back(32'h0);
    run_i  = 1'b1;
    step_i = 1'b1;
    tick();
    run_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL step_priority: st=%0d, expected 2", state_o);
    end
    tick();
    step_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (pc !== 32'h4 || state_o !== 2'd0 || instr_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL step_priority_done: pc=%h st=%0d cnt=%0d, expected 4/0/1", pc, state_o, instr_cnt);
    end
    tick();
  endtask

  task automatic test_counter_wrap;
    exp_q.push_back(32'h4);
    @(negedge clk);
    force dut.r_instr_cnt = 32'hFFFF_FFFF;
    tick();
    step_i = 1'b1;
    tick();
    @(negedge clk);
    release dut.r_instr_cnt;
    tick();
    step_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (instr_cnt !== 32'h0 || pc !== 32'h8) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt=%h pc=%h, expected 0/8", instr_cnt, pc);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: %0d commits missing, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b0; run_i = 1'b0; step_i = 1'b0; brk_en = 1'b0; stop = 1'b0;
    brk_addr = 32'h0; imm = 32'h0; alu_result = 32'h0; jalmux_sel = 2'b00;
    test_reset();
    test_single_step();
    test_npc_paths();
    test_breakpoint();
    test_halt();
    test_reset_mid_run();
    test_back_to_back();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control and program-counter sequencer for the single-cycle RV32 core. Owns the PC register, computes next-PC from the decoder's jump/branch selects, and gates architectural commits (register-file write, data-memory write) through a run/step/breakpoint/halt state machine. Sits between the board-level debug inputs and the datapath: `pc` feeds instruction fetch, and `cpu_en` qualifies every state-changing write.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `run_i`  in  1  level; 1 = free-run requested.
- `step_i`  in  1  single-step request, debounced level; rising edge detected internally.
- `brk_en`  in  1  breakpoint enable.
- `brk_addr`  in  32  breakpoint PC.
- `stop`  in  1  decoder flag for an illegal/terminating opcode at the current PC.
- `jalmux_sel`  in  2  next-PC select: 00 seq, 01 branch/jal, 1x jalr.
- `imm`  in  32  decoder immediate; the SB/UJ offset is in halfword units.
- `alu_result`  in  32  ALU output, used as the jalr target.
- `pc`  out  32  current PC.
- `cpu_en`  out  1  commit enable for the current instruction.
- `state_o`  out  2  FSM state, for debug display.
- `halted`  out  1  sticky halt indicator.
- `instr_cnt`  out  32  count of committed instructions.

## Operation
- Next PC:
  - seq: `pc+4`.
  - branch/jal: `pc + (imm<<1)`.
  - jalr: `alu_result & ~32'h1`.
  - All arithmetic is mod 2^32; wrap is silent.
- Commit condition: `commit = cpu_en`. On commit, `pc` ← next PC and `instr_cnt` ← `instr_cnt+1`, wrapping to 0 after 32'hFFFF_FFFF.
- `cpu_en = (state==RUN || state==STEP) && !stop && !bp_hit`.
- `bp_hit = brk_en && pc==brk_addr && !resume`.
- `resume` is set on every exit from PAUSE into RUN or STEP and cleared after the first commit. This lets execution continue past the breakpoint it stopped on.
- Step edge: `step_pulse = step_i & ~step_q`. `step_q` is registered and resets to 0.
- FSM states: PAUSE=0, RUN=1, STEP=2, HALT=3.
  - PAUSE: if `step_pulse` → STEP; else if `run_i` → RUN. Step wins when both occur together.
  - RUN, with priority `stop` > `bp_hit` > `!run_i`:
    - `stop` → HALT with no commit.
    - `bp_hit` → PAUSE with no commit.
    - `!run_i` → PAUSE. The current cycle still commits if `cpu_en`=1.
    - Otherwise stay in RUN.
  - STEP: `stop` → HALT with no commit; otherwise commit exactly one instruction → PAUSE. A breakpoint cannot fire in STEP because `resume`=1 there.
  - HALT: sticky; only `rst` leaves it. `halted`=1.
- `step_pulse` arriving while in RUN, STEP or HALT is ignored.

## Timing
- Reset values: `pc`=`PC_RESET`, state=PAUSE, `cpu_en`=0, `halted`=0, `instr_cnt`=0, `state_o`=0, `resume`=0, `step_q`=0.
- Reset asserted mid-RUN: the next edge loads reset values, and no commit occurs in that cycle (`cpu_en` is forced to 0 while `rst`=0).
- `cpu_en` is combinational from state, `pc`, `stop` and the breakpoint inputs. `pc`, state and counters are registered.
- Step latency: `step_i` rises before edge n → STEP after edge n → `pc` updated at edge n+1 → PAUSE after edge n+1.
- RUN throughput: one commit per cycle.
- `stop` at PC X in RUN: HALT after the next edge; `pc` stays at X.

## Structure
- Package `cpu_ctrl_pkg`:
  - State encodings `ST_PAUSE`/`ST_RUN`/`ST_STEP`/`ST_HALT`.
  - Next-PC select codes `NPC_SEQ`=2'b00, `NPC_BR`=2'b01, `NPC_JALR`=2'b1x.
- Sub-module `npc_gen`: purely combinational next-PC mux and adders. The FSM, counters and edge detector stay in `cpu_run_ctrl`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles → `pc`=0, `cpu_en`=0, state=PAUSE, `instr_cnt`=0.
- **Single step:** in PAUSE with `pc`=0, `jalmux_sel`=00, pulse `step_i` → exactly one `cpu_en` cycle, `pc`=4, `instr_cnt`=1, back to PAUSE. Holding `step_i` high produces no further steps.
- **Next-PC paths:** in RUN at `pc`=0x10, `jalmux_sel`=01 with `imm`=0xFFFFFFFC → `pc`=0x08. Then `jalmux_sel`=10 with `alu_result`=0x21 → `pc`=0x20.
- **Breakpoint:** `brk_en`=1, `brk_addr`=0x0C, RUN from 0 sequential → commits at 0, 4 and 8, then PAUSE with `pc`=0x0C and `cpu_en`=0. Re-asserting run commits 0x0C and proceeds to 0x10.
- **Halt:** `stop`=1 at `pc`=0x08 in RUN → no commit, HALT, `halted`=1, `pc` stays 0x08. `run_i` and `step_i` are then ignored until `rst`.
- **Counter wrap:** force `instr_cnt`=0xFFFFFFFF, step once → `instr_cnt`=0.
